// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes the serial line, frames 8N1 bytes
// sampled at mid-bit, and reports good bytes and framing errors as one-cycle pulses.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_serial,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] counter
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } state_t;

  state_t           state, state_next;
  logic             sync_ff1, rx_s;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_next;
  logic [CNT_W-1:0] counter_next;
  logic             valid_next, ferr_next;

  // Synchronizer resets high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1  <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      counter   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_ff1  <= rx_serial;
      rx_s      <= sync_ff1;
      state     <= state_next;
      counter   <= counter_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter + CNT_W'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = rx_data;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;

    unique case (state)
      IDLE: begin
        counter_next = '0;
        if (!rx_s) state_next = START;
      end

      // Half a period in, the start bit must still be low or it was a glitch.
      START: begin
        if (counter == HALF_M1) begin
          counter_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (counter == LAST) begin
          counter_next = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end

      // Leaving mid stop bit lets a back-to-back start edge be caught.
      STOP: begin
        if (counter == LAST) begin
          counter_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BRK_WAIT;
          end
        end
      end

      BRK_WAIT: begin
        counter_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        counter_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: a fast 16 clk/bit instance for most
// scenarios plus a default-parameter instance fed a bit period 3% short.
module tb_uart_rx_deserializer;

  localparam int C     = 16;
  localparam int H     = C / 2;
  localparam int C_DEF = 10417;
  localparam int C_SKW = 10104;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_serial = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, busy;
  logic [3:0]  counter;

  logic        rst_n_d = 1'b0;
  logic        rx_serial_d = 1'b1;
  logic [7:0]  rx_data_d;
  logic        rx_valid_d, frame_err_d, busy_d;
  logic [13:0] counter_d;

  int check_cnt = 0, error_cnt = 0;
  int cyc = 0, start_cyc = 0, pulse_cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, overlap_cnt = 0, double_cnt = 0;
  int valid_d_cnt = 0, ferr_d_cnt = 0;
  int v0, f0, lo;
  logic prev_valid = 1'b0, prev_ferr = 1'b0;
  logic [7:0] last_data = 8'h00, data_d = 8'h00, first_data = 8'h00;

  uart_rx_deserializer #(.CLKS_PER_BIT(C), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy), .counter(counter)
  );

  uart_rx_deserializer dut_def (
    .clk(clk), .rst_n(rst_n_d), .rx_serial(rx_serial_d), .rx_data(rx_data_d),
    .rx_valid(rx_valid_d), .frame_err(frame_err_d), .busy(busy_d), .counter(counter_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts pulses and flags overlap or stretched pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_data = rx_data;
      pulse_cyc = cyc;
      if (valid_cnt == 1) first_data = rx_data;
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) overlap_cnt++;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) double_cnt++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    if (rx_valid_d) begin
      valid_d_cnt++;
      data_d = rx_data_d;
    end
    if (frame_err_d) ferr_d_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame; must be called right after a posedge and ends on one.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int bit_clks, input bit on_default);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    if (!on_default) start_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (on_default) rx_serial_d = frame[i];
      else            rx_serial   = frame[i];
      repeat (bit_clks) @(posedge clk);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_data"},  32'(rx_data), 32'h00);
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'h0);
    checkOutput({tag, "_ferr"},  32'(frame_err), 32'h0);
    checkOutput({tag, "_busy"},  32'(busy), 32'h0);
    checkOutput({tag, "_cnt"},   32'(counter), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkReset("rst");
    rst_n   = 1'b1;
    rst_n_d = 1'b1;
    repeat (5) @(posedge clk);

    fork
      begin
        // Frame 0xA5 with latency window check
        applyStimulus(8'hA5, 1'b1, C, 1'b0);
        repeat (C) @(posedge clk);
        checkOutput("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        checkOutput("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
        checkOutput("t1_data", 32'(rx_data), 32'hA5);
        lo = start_cyc + 1 + 2 + H + 9 * C;
        checkOutput("t1_latency", 32'((pulse_cyc >= lo) && (pulse_cyc <= lo + 2)), 32'd1);

        // Short low glitch is rejected
        v0 = valid_cnt; f0 = ferr_cnt;
        #1 rx_serial = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_serial = 1'b1;
        checkOutput("t2_busy_mid", 32'(busy), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t2_busy_end", 32'(busy), 32'd0);
        checkOutput("t2_valid", 32'(valid_cnt - v0), 32'd0);
        checkOutput("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
        repeat (2 * C) @(posedge clk);

        // Framing error followed by a held-low break
        v0 = valid_cnt; f0 = ferr_cnt;
        applyStimulus(8'h3C, 1'b0, C, 1'b0);
        repeat (100 - C) @(posedge clk);
        #1;
        checkOutput("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("t3_valid", 32'(valid_cnt - v0), 32'd0);
        checkOutput("t3_data_kept", 32'(rx_data), 32'hA5);
        checkOutput("t3_busy_break", 32'(busy), 32'd1);
        rx_serial = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t3_busy_end", 32'(busy), 32'd0);
        repeat (2 * C) @(posedge clk);
        checkOutput("t3_no_restart", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        v0 = valid_cnt; f0 = ferr_cnt;
        applyStimulus(8'h00, 1'b1, C, 1'b0);
        checkOutput("t4_first", 32'(last_data), 32'h00);
        applyStimulus(8'hFF, 1'b1, C, 1'b0);
        repeat (C) @(posedge clk);
        checkOutput("t4_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        checkOutput("t4_second", 32'(rx_data), 32'hFF);
        checkOutput("t4_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Reset during data bit 3 of 0x81, then 0x5A
        v0 = valid_cnt; f0 = ferr_cnt;
        #1 rx_serial = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          #1 rx_serial = (i == 0);
          repeat (C) @(posedge clk);
        end
        #1 rx_serial = 1'b0;
        repeat (H) @(posedge clk);
        #1 rst_n = 1'b0;
        rx_serial = 1'b1;
        #1;
        checkReset("t5_rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * C) @(posedge clk);
        checkOutput("t5_abort", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
        applyStimulus(8'h5A, 1'b1, C, 1'b0);
        repeat (C) @(posedge clk);
        checkOutput("t5_valid", 32'(valid_cnt - v0), 32'd1);
        checkOutput("t5_data", 32'(rx_data), 32'h5A);
        checkOutput("t5_ferr", 32'(ferr_cnt - f0), 32'd0);
      end
      begin
        // Default bit period, line running 3% fast
        repeat (20) @(posedge clk);
        applyStimulus(8'hC3, 1'b1, C_SKW, 1'b1);
        repeat (C_DEF / 2) @(posedge clk);
        checkOutput("t6_valid_cnt", 32'(valid_d_cnt), 32'd1);
        checkOutput("t6_data", 32'(data_d), 32'hC3);
        checkOutput("t6_ferr", 32'(ferr_d_cnt), 32'd0);
      end
    join

    checkOutput("overlap", 32'(overlap_cnt), 32'd0);
    checkOutput("stretched", 32'(double_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
